// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
// Holds the FSM state encoding (also decoded by the debug/CSR block through seq_state),
// the state width, and a small helper for sizing the shared cycle counter.
package pll_seq_pkg;

  localparam int unsigned SeqStateW = 2;

  typedef enum logic [SeqStateW-1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Bundle between the PLL reset sequencer and its PLL / reset-consumer surroundings.
//   pll_lock      : PLL lock, asynchronous to the sequencer clock
//   soft_rst_req  : single-cycle request for a full PLL re-sequence
//   pll_reset     : active-high PLL reset
//   sys_rst_n     : active-low downstream system reset
//   seq_ready     : high only while running
//   seq_state     : encoded FSM state
//   relock_cnt    : saturating re-sequence count
//   timeout_flag  : sticky lock-timeout indication
// master = sequencer side, slave = environment side.
interface pll_rst_seq_if
  import pll_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) ();

  logic                 pll_lock;
  logic                 soft_rst_req;
  logic                 pll_reset;
  logic                 sys_rst_n;
  logic                 seq_ready;
  logic [SeqStateW-1:0] seq_state;
  logic [CNT_W-1:0]     relock_cnt;
  logic                 timeout_flag;

  modport master (
    input  pll_lock,
    input  soft_rst_req,
    output pll_reset,
    output sys_rst_n,
    output seq_ready,
    output seq_state,
    output relock_cnt,
    output timeout_flag
  );

  modport slave (
    output pll_lock,
    output soft_rst_req,
    input  pll_reset,
    input  sys_rst_n,
    input  seq_ready,
    input  seq_state,
    input  relock_cnt,
    input  timeout_flag
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level signals, reset to 0.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output (two destination-clock cycles of latency)
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer in the reference-clock domain.
// Holds the PLL in reset, waits for a synchronized lock, requires the lock to stay stable for
// STABLE_CYCLES before releasing the downstream system reset, and re-sequences on lock loss,
// lock timeout or soft request while keeping relock/timeout statistics.
//   clk    : reference clock
//   rst_n  : asynchronous active-low reset
//   seq_if : master side of pll_rst_seq_if (lock/soft request in, resets and status out)
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pll_rst_seq_if.master      seq_if
);

  localparam int unsigned CntW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);

  logic lock_s;

  sync_2ff #(
    .Width(1)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (seq_if.pll_lock),
    .q_o   (lock_s)
  );

  seq_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic             timeout_q, timeout_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             seq_ready_q, seq_ready_d;
  logic             relock_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    timeout_d  = timeout_q;
    relock_d   = relock_q;
    relock_inc = 1'b0;

    case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d    = StPllRst;
          cnt_d      = '0;
          timeout_d  = 1'b1;
          relock_inc = 1'b1;
        end
      end
      StStable: begin
        // A single low synchronized sample restarts the lock wait without counting a relock.
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d    = StPllRst;
          cnt_d      = '0;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    // Soft request overrides everything; a request while already in reset only restarts
    // the reset window.
    if (seq_if.soft_rst_req) begin
      state_d    = StPllRst;
      cnt_d      = '0;
      timeout_d  = timeout_q;
      relock_inc = (state_q != StPllRst);
    end

    if (relock_inc && (relock_q != '1)) begin
      relock_d = relock_q + 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_q.
    pll_reset_d = (state_d == StPllRst);
    sys_rst_n_d = (state_d == StRun);
    seq_ready_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      relock_q    <= '0;
      timeout_q   <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      seq_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      relock_q    <= relock_d;
      timeout_q   <= timeout_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      seq_ready_q <= seq_ready_d;
    end
  end

  assign seq_if.pll_reset    = pll_reset_q;
  assign seq_if.sys_rst_n    = sys_rst_n_q;
  assign seq_if.seq_ready    = seq_ready_q;
  assign seq_if.seq_state    = state_q;
  assign seq_if.relock_cnt   = relock_q;
  assign seq_if.timeout_flag = timeout_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed self-checking bench for pll_rst_seq with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, CNT_W=8.
module tb_pll_rst_seq;
  import pll_seq_pkg::*;

  localparam int unsigned RstCycles    = 4;
  localparam int unsigned LockTimeout  = 20;
  localparam int unsigned StableCycles = 8;
  localparam int unsigned CntW         = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pll_rst_seq_if #(.CNT_W(CntW)) seq_if ();

  pll_rst_seq #(
    .RST_CYCLES   (RstCycles),
    .LOCK_TIMEOUT (LockTimeout),
    .STABLE_CYCLES(StableCycles),
    .CNT_W        (CntW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_if(seq_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts clock edges while pll_reset stays at val (bounded).
  task automatic count_reset(input logic val, output int n);
    n = 0;
    while (seq_if.pll_reset === val && n < 100) begin
      tick();
      n++;
    end
  endtask

  // Counts clock edges until sys_rst_n reaches val (bounded).
  task automatic count_sys(input logic val, output int n);
    n = 0;
    while (seq_if.sys_rst_n !== val && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_sys(input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (seq_if.sys_rst_n !== val && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(seq_if.sys_rst_n), 32'(val));
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string tag);
    int n;
    n = 0;
    while (seq_if.seq_state !== st && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(seq_if.seq_state), 32'(st));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pll_reset"}, 32'(seq_if.pll_reset), 1);
    check_eq({tag, "_sys_rst_n"}, 32'(seq_if.sys_rst_n), 0);
    check_eq({tag, "_ready"}, 32'(seq_if.seq_ready), 0);
    check_eq({tag, "_state"}, 32'(seq_if.seq_state), 32'(StPllRst));
    check_eq({tag, "_relock"}, 32'(seq_if.relock_cnt), 0);
    check_eq({tag, "_timeout"}, 32'(seq_if.timeout_flag), 0);
  endtask

  initial begin
    int n;
    seq_if.pll_lock     = 1'b0;
    seq_if.soft_rst_req = 1'b0;
    rst_n               = 1'b0;

    // Reset values.
    #12;
    check_reset_vals("rst");
    tick();
    rst_n = 1'b1;

    // Power-up: 4-cycle PLL reset, then lock captured 3 edges after the fall.
    count_reset(1'b1, n);
    check_eq("pwr_rst_len", n, 4);
    check_eq("pwr_wait_state", 32'(seq_if.seq_state), 32'(StWaitLock));
    tick();
    tick();
    seq_if.pll_lock = 1'b1;
    tick();  // edge capturing the lock
    count_sys(1'b1, n);
    check_eq("pwr_release_lat", n, 10);  // 2 sync + 8 stable
    check_eq("pwr_ready", 32'(seq_if.seq_ready), 1);
    check_eq("pwr_state", 32'(seq_if.seq_state), 32'(StRun));
    check_eq("pwr_relock", 32'(seq_if.relock_cnt), 0);
    check_eq("pwr_timeout", 32'(seq_if.timeout_flag), 0);
    check_eq("pwr_pll_reset", 32'(seq_if.pll_reset), 0);

    // Lock loss in RUN.
    seq_if.pll_lock = 1'b0;
    count_sys(1'b0, n);
    check_eq("loss_lat", n, 3);
    check_eq("loss_pll_reset", 32'(seq_if.pll_reset), 1);
    check_eq("loss_relock", 32'(seq_if.relock_cnt), 1);
    check_eq("loss_ready", 32'(seq_if.seq_ready), 0);
    count_reset(1'b1, n);
    check_eq("loss_rst_len", n, 4);

    // Re-lock with a one-cycle synchronized glitch at stable count 5.
    seq_if.pll_lock = 1'b1;
    wait_state(StStable, 20, "glitch_enter_stable");
    tick();
    tick();
    tick();
    seq_if.pll_lock = 1'b0;
    tick();
    seq_if.pll_lock = 1'b1;
    tick();
    check_eq("glitch_still_stable", 32'(seq_if.seq_state), 32'(StStable));
    tick();
    check_eq("glitch_back_wait", 32'(seq_if.seq_state), 32'(StWaitLock));
    check_eq("glitch_sys_low", 32'(seq_if.sys_rst_n), 0);
    count_sys(1'b1, n);
    check_eq("glitch_release_lat", n, 9);  // 1 to STABLE + full 8 stable
    check_eq("glitch_relock", 32'(seq_if.relock_cnt), 1);

    // Soft request in RUN, then again in PLL_RST.
    seq_if.soft_rst_req = 1'b1;
    tick();
    seq_if.soft_rst_req = 1'b0;
    seq_if.pll_lock     = 1'b0;
    check_eq("soft_state", 32'(seq_if.seq_state), 32'(StPllRst));
    check_eq("soft_sys_low", 32'(seq_if.sys_rst_n), 0);
    check_eq("soft_pll_reset", 32'(seq_if.pll_reset), 1);
    check_eq("soft_relock", 32'(seq_if.relock_cnt), 2);
    tick();
    tick();
    seq_if.soft_rst_req = 1'b1;
    tick();
    seq_if.soft_rst_req = 1'b0;
    check_eq("soft2_relock", 32'(seq_if.relock_cnt), 2);
    count_reset(1'b1, n);
    check_eq("soft2_rst_len", n, 4);
    check_eq("soft2_wait_state", 32'(seq_if.seq_state), 32'(StWaitLock));
    check_eq("soft_no_timeout", 32'(seq_if.timeout_flag), 0);

    // Lock never asserts: 4 high / 20 low pulses, relock counting, sticky timeout.
    for (int k = 0; k < 2; k++) begin
      count_reset(1'b0, n);
      check_eq("to_low_len", n, 20);
      check_eq("to_flag", 32'(seq_if.timeout_flag), 1);
      check_eq("to_relock", 32'(seq_if.relock_cnt), 32'(3 + k));
      check_eq("to_sys_low", 32'(seq_if.sys_rst_n), 0);
      count_reset(1'b1, n);
      check_eq("to_high_len", n, 4);
    end

    // 300 lock losses in RUN: relock_cnt saturates.
    for (int i = 0; i < 300; i++) begin
      seq_if.pll_lock = 1'b1;
      wait_sys(1'b1, 100, "sat_release");
      seq_if.pll_lock = 1'b0;
      wait_sys(1'b0, 10, "sat_loss");
      if (i == 0) check_eq("sat_first_inc", 32'(seq_if.relock_cnt), 5);
    end
    check_eq("sat_relock", 32'(seq_if.relock_cnt), 255);
    check_eq("sat_timeout_sticky", 32'(seq_if.timeout_flag), 1);

    // Asynchronous reset mid-STABLE.
    seq_if.pll_lock = 1'b1;
    wait_state(StStable, 100, "mid_enter_stable");
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
